cfu_initiator: RTL and testbench

- CPU-side initiator for the general CFU request/response interface.
- Accepts commands from the core and issues tagged CFU requests, tracking up to DEPTH outstanding transactions.
- Accepts responses in any order and returns completions to the core strictly in issue order.
- Sits between the core execute stage and any CFU, including comb- and pipeline-adapted CFUs.

---
 rtl/cfu_initiator.sv | 138 +++++++++++++
 tb/tb_cfu_initiator.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cfu_initiator.sv
// cfu_initiator: CPU-side CFU initiator issuing tagged requests and retiring completions in issue order.
// Ports:
//   clock_i, reset_ni (async, active-low), clock_en_i (freezes all handshakes/state when low)
//   cmd_*   : core command in (valid/ready), passed straight through to req_*
//   req_*   : CFU request out, req_id_o is the allocated slot tag
//   resp_*  : CFU response in, accepted in any order by tag
//   cpl_*   : in-order completion back to the core
//   outstanding_o : issued-but-not-retired count; stray_resp_o : one-cycle pulse on an unmatched response
module cfu_initiator #(
  parameter int DEPTH              = 4,
  parameter int CFU_INTERFACE_ID_W = 16,
  parameter int CFU_FUNCTION_ID_W  = 16,
  parameter int CFU_REORDER_ID_W   = 8,
  parameter int CFU_REQ_RESP_ID_W  = 6,
  parameter int CFU_REQ_INPUTS     = 2,
  parameter int CFU_REQ_DATA_W     = 32,
  parameter int CFU_RESP_OUTPUTS   = 1,
  parameter int CFU_RESP_DATA_W    = CFU_REQ_DATA_W,
  parameter int CFU_ERROR_ID_W     = CFU_RESP_DATA_W
) (
  input  logic                                        clock_i,
  input  logic                                        reset_ni,
  input  logic                                        clock_en_i,
  output logic                                        cmd_ready_o,
  input  logic                                        cmd_valid_i,
  input  logic [CFU_INTERFACE_ID_W-1:0]               cmd_interface_id_i,
  input  logic [CFU_FUNCTION_ID_W-1:0]                cmd_function_id_i,
  input  logic [CFU_REORDER_ID_W-1:0]                 cmd_reorder_id_i,
  input  logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]    cmd_data_i,
  input  logic                                        req_ready_i,
  output logic                                        req_valid_o,
  output logic [CFU_INTERFACE_ID_W-1:0]               req_interface_id_o,
  output logic [CFU_FUNCTION_ID_W-1:0]                req_function_id_o,
  output logic [CFU_REORDER_ID_W-1:0]                 req_reorder_id_o,
  output logic [CFU_REQ_RESP_ID_W-1:0]                req_id_o,
  output logic [CFU_REQ_INPUTS*CFU_REQ_DATA_W-1:0]    req_data_o,
  output logic                                        resp_ready_o,
  input  logic                                        resp_valid_i,
  input  logic [CFU_REQ_RESP_ID_W-1:0]                resp_id_i,
  input  logic [CFU_RESP_OUTPUTS*CFU_RESP_DATA_W-1:0] resp_data_i,
  input  logic                                        resp_ok_i,
  input  logic [CFU_ERROR_ID_W-1:0]                   resp_error_id_i,
  input  logic                                        cpl_ready_i,
  output logic                                        cpl_valid_o,
  output logic [CFU_RESP_OUTPUTS*CFU_RESP_DATA_W-1:0] cpl_data_o,
  output logic                                        cpl_ok_o,
  output logic [CFU_ERROR_ID_W-1:0]                   cpl_error_id_o,
  output logic [$clog2(DEPTH+1)-1:0]                  outstanding_o,
  output logic                                        stray_resp_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int DW = CFU_RESP_OUTPUTS * CFU_RESP_DATA_W;
  logic [PW-1:0]             head_q, head_d, tail_q, tail_d, ridx;
  logic [CW-1:0]             count_q, count_d;
  logic [DEPTH-1:0]          pend_q, pend_d, done_q, done_d, ok_q, ok_d;
  logic [DW-1:0]             data_q [DEPTH];
  logic [DW-1:0]             data_d [DEPTH];
  logic [CFU_ERROR_ID_W-1:0] err_q [DEPTH];
  logic [CFU_ERROR_ID_W-1:0] err_d [DEPTH];
  logic                      rready_q, stray_q, stray_d;
  logic                      full, issue, retire, rv, match;
  assign full               = count_q == CW'(DEPTH);
  assign req_valid_o        = cmd_valid_i && !full;
  assign cmd_ready_o        = req_ready_i && !full;
  assign req_interface_id_o = cmd_interface_id_i;
  assign req_function_id_o  = cmd_function_id_i;
  assign req_reorder_id_o   = cmd_reorder_id_i;
  assign req_data_o         = cmd_data_i;
  assign req_id_o           = CFU_REQ_RESP_ID_W'(tail_q);
  assign issue              = req_valid_o && req_ready_i && clock_en_i;
  assign rv                 = resp_valid_i && rready_q && clock_en_i;
  assign ridx               = resp_id_i[PW-1:0];
  // A response may target the slot being issued this very cycle (comb CFU), before its pending bit exists.
  assign match              = rv && (32'(resp_id_i) < DEPTH) &&
                              ((pend_q[ridx] && !done_q[ridx]) || (issue && ridx == tail_q));
  assign cpl_valid_o        = done_q[head_q];
  assign cpl_data_o         = data_q[head_q];
  assign cpl_ok_o           = ok_q[head_q];
  assign cpl_error_id_o     = err_q[head_q];
  assign retire             = cpl_valid_o && cpl_ready_i && clock_en_i;
  assign resp_ready_o       = rready_q;
  assign outstanding_o      = count_q;
  assign stray_resp_o       = stray_q;
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    pend_d  = pend_q;
    done_d  = done_q;
    ok_d    = ok_q;
    data_d  = data_q;
    err_d   = err_q;
    if (issue) begin
      pend_d[tail_q] = 1'b1;
      tail_d         = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
    end
    if (match) begin
      done_d[ridx] = 1'b1;
      data_d[ridx] = resp_data_i;
      ok_d[ridx]   = resp_ok_i;
      err_d[ridx]  = resp_error_id_i;
    end
    if (retire) begin
      pend_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + 1'b1;
    end
    count_d = count_q + CW'(issue) - CW'(retire);
    stray_d = rv && !match;
  end
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      pend_q   <= '0;
      done_q   <= '0;
      ok_q     <= '0;
      rready_q <= 1'b0;
      stray_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        err_q[i]  <= '0;
      end
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
      done_q   <= done_d;
      ok_q     <= ok_d;
      data_q   <= data_d;
      err_q    <= err_d;
      rready_q <= 1'b1;
      stray_q  <= stray_d;
    end
  end
endmodule

// File: tb/tb_cfu_initiator.sv
// tb_cfu_initiator: table, hand-sequence and random checks of cfu_initiator against an issue-order queue model.
module tb_cfu_initiator;
  logic        clk = 1'b0, rst_n, ce;
  logic        cmd_ready, cmd_valid, req_ready, req_valid;
  logic [15:0] cmd_if, cmd_fn, req_if, req_fn;
  logic [7:0]  cmd_ro, req_ro;
  logic [63:0] cmd_data, req_data;
  logic [5:0]  req_id, resp_id;
  logic        resp_ready, resp_valid, resp_ok, cpl_ready, cpl_valid, cpl_ok, stray;
  logic [31:0] resp_data, resp_err, cpl_data, cpl_err;
  logic [2:0]  outstanding;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  cfu_initiator dut (
    .clock_i(clk), .reset_ni(rst_n), .clock_en_i(ce),
    .cmd_ready_o(cmd_ready), .cmd_valid_i(cmd_valid), .cmd_interface_id_i(cmd_if),
    .cmd_function_id_i(cmd_fn), .cmd_reorder_id_i(cmd_ro), .cmd_data_i(cmd_data),
    .req_ready_i(req_ready), .req_valid_o(req_valid), .req_interface_id_o(req_if),
    .req_function_id_o(req_fn), .req_reorder_id_o(req_ro), .req_id_o(req_id), .req_data_o(req_data),
    .resp_ready_o(resp_ready), .resp_valid_i(resp_valid), .resp_id_i(resp_id), .resp_data_i(resp_data),
    .resp_ok_i(resp_ok), .resp_error_id_i(resp_err),
    .cpl_ready_i(cpl_ready), .cpl_valid_o(cpl_valid), .cpl_data_o(cpl_data), .cpl_ok_o(cpl_ok),
    .cpl_error_id_o(cpl_err), .outstanding_o(outstanding), .stray_resp_o(stray)
  );
  typedef struct {
    bit cv, rqr, rsv; bit [5:0] rid; bit [31:0] rd; bit rok; bit [31:0] rerr; bit cr, ce;
    bit e_cv; bit [31:0] e_cd; int e_out; bit e_st; bit e_rv;
  } vec_t;
  typedef struct { int tag; bit done; bit [31:0] d; bit ok; bit [31:0] e; } ent_t;
  ent_t mq[$];
  int   m_tail;
  bit   m_rr, m_stray;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask
  function automatic vec_t mk(bit cv, bit rqr, bit rsv, bit [5:0] rid, bit [31:0] rd, bit rok, bit [31:0] rerr,
                              bit cr, bit cen, bit e_cv, bit [31:0] e_cd, int e_out, bit e_st, bit e_rv);
    vec_t v;
    v.cv = cv; v.rqr = rqr; v.rsv = rsv; v.rid = rid; v.rd = rd; v.rok = rok; v.rerr = rerr;
    v.cr = cr; v.ce = cen; v.e_cv = e_cv; v.e_cd = e_cd; v.e_out = e_out; v.e_st = e_st; v.e_rv = e_rv;
    return v;
  endfunction
  function automatic vec_t nv(bit cv, bit rqr, bit rsv, bit [5:0] rid, bit [31:0] rd, bit cr, bit cen);
    return mk(cv, rqr, rsv, rid, rd, 1'b1, 32'h0, cr, cen, 0, 0, 0, 0, 0);
  endfunction
  task automatic m_reset();
    mq.delete();
    m_tail = 0; m_rr = 0; m_stray = 0;
  endtask
  task automatic model_check(input vec_t v);
    bit full, cv;
    full = mq.size() == 4;
    cv   = mq.size() > 0 && mq[0].done;
    chk("req_valid", req_valid, v.cv && !full);
    chk("cmd_ready", cmd_ready, v.rqr && !full);
    chk("req_id", req_id, m_tail);
    chk("req_data", req_data, cmd_data);
    chk("req_fields", {req_if, req_fn, req_ro}, {cmd_if, cmd_fn, cmd_ro});
    chk("resp_ready", resp_ready, m_rr);
    chk("cpl_valid", cpl_valid, cv);
    if (cv) begin
      chk("cpl_data", cpl_data, mq[0].d);
      chk("cpl_ok", cpl_ok, mq[0].ok);
      chk("cpl_error_id", cpl_err, mq[0].e);
    end
    chk("outstanding", outstanding, mq.size());
    chk("stray_resp", stray, m_stray);
  endtask
  task automatic model_step(input vec_t v);
    bit full, issue, rv, retire, hit, newdone;
    full    = mq.size() == 4;
    issue   = v.cv && !full && v.rqr && v.ce;
    rv      = v.rsv && m_rr && v.ce;
    retire  = mq.size() > 0 && mq[0].done && v.cr && v.ce;
    hit     = 0;
    newdone = 0;
    if (rv && v.rid < 4) begin
      foreach (mq[i])
        if (mq[i].tag == int'(v.rid) && !mq[i].done) begin
          mq[i].done = 1; mq[i].d = v.rd; mq[i].ok = v.rok; mq[i].e = v.rerr; hit = 1;
        end
      newdone = !hit && issue && int'(v.rid) == m_tail;
      hit     = hit || newdone;
    end
    if (retire) void'(mq.pop_front());
    if (issue) begin
      mq.push_back('{m_tail, newdone, v.rd, v.rok, v.rerr});
      m_tail = (m_tail + 1) % 4;
    end
    m_stray = rv && !hit;
    m_rr    = 1;
  endtask
  task automatic cyc(input vec_t v, input bit tab);
    cmd_valid = v.cv; req_ready = v.rqr; resp_valid = v.rsv; resp_id = v.rid; resp_data = v.rd;
    resp_ok = v.rok; resp_err = v.rerr; cpl_ready = v.cr; ce = v.ce;
    #1;
    model_check(v);
    if (tab) begin
      chk("tab_cpl_valid", cpl_valid, v.e_cv);
      if (v.e_cv) chk("tab_cpl_data", cpl_data, v.e_cd);
      chk("tab_outstanding", outstanding, v.e_out);
      chk("tab_stray", stray, v.e_st);
      chk("tab_req_valid", req_valid, v.e_rv);
    end
    model_step(v);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic idle_inputs();
    cmd_valid = 0; req_ready = 0; resp_valid = 0; resp_id = 0; resp_data = 0;
    resp_ok = 0; resp_err = 0; cpl_ready = 0; ce = 1;
  endtask
  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    #1;
    m_reset();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_cpl_valid", cpl_valid, 0);
    chk("rst_stray", stray, 0);
    chk("rst_outstanding", outstanding, 0);
    @(negedge clk);
    rst_n = 1;
  endtask
  vec_t tab[$];
  initial begin
    cmd_if = 16'h1; cmd_fn = 16'h2; cmd_ro = 8'h3; cmd_data = {32'd5, 32'd3};
    //           cv rqr rsv rid rd       ok err     cr ce  e_cv e_cd     out st rv
    tab.push_back(mk(1, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   0, 0, 1));
    tab.push_back(mk(1, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   1, 0, 1));
    tab.push_back(mk(1, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   2, 0, 1));
    tab.push_back(mk(0, 1, 1, 2, 32'h20, 1, 32'h0,  1, 1,  0,   32'h0,   3, 0, 0));
    tab.push_back(mk(0, 1, 1, 0, 32'h00, 1, 32'h0,  1, 1,  0,   32'h0,   3, 0, 0));
    tab.push_back(mk(0, 1, 1, 1, 32'h10, 1, 32'h0,  1, 1,  1,   32'h00,  3, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  1,   32'h10,  2, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  1,   32'h20,  1, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   0, 0, 0));
    tab.push_back(mk(1, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   0, 0, 1));
    tab.push_back(mk(0, 1, 1, 2, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   1, 0, 0));
    tab.push_back(mk(0, 1, 1, 9, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   1, 1, 0));
    tab.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   1, 1, 0));
    tab.push_back(mk(0, 1, 1, 3, 32'h77, 1, 32'h0,  1, 1,  0,   32'h0,   1, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  1,   32'h77,  1, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   0, 0, 0));
    tab.push_back(mk(1, 1, 1, 0, 32'h99, 0, 32'h55, 1, 1,  0,   32'h0,   0, 0, 1));
    tab.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  1,   32'h99,  1, 0, 0));
    tab.push_back(mk(0, 1, 0, 0, 32'h0,  1, 32'h0,  1, 1,  0,   32'h0,   0, 0, 0));
    do_reset();
    for (int i = 0; i < tab.size(); i++) cyc(tab[i], 1'b1);
    do_reset();
    for (int i = 0; i < 4; i++) cyc(nv(1, 1, 0, 0, 0, 0, 1), 0);
    cyc(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 4, 0, 0), 1);
    cyc(nv(1, 1, 1, 0, 32'hAB, 0, 1), 0);
    cyc(mk(1, 1, 0, 0, 0, 1, 0, 1, 1, 1, 32'hAB, 4, 0, 0), 1);
    chk("wrap_req_id", req_id, 0);
    cyc(mk(1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, 3, 0, 1), 1);
    chk("wrap_refill", outstanding, 4);
    do_reset();
    for (int i = 0; i < 3; i++) cyc(nv(1, 1, 0, 0, 0, 0, 1), 0);
    cyc(nv(0, 1, 1, 1, 32'h11, 0, 1), 0);
    for (int i = 0; i < 5; i++) cyc(nv(1, 1, 1, 6'(i % 3), 32'hEE, 1, 0), 0);
    cyc(mk(0, 1, 1, 0, 32'h22, 1, 0, 0, 1, 0, 0, 3, 0, 0), 1);
    idle_inputs();
    #2 rst_n = 0;
    #1;
    m_reset();
    chk("mid_rst_outstanding", outstanding, 0);
    chk("mid_rst_cpl_valid", cpl_valid, 0);
    chk("mid_rst_resp_ready", resp_ready, 0);
    @(negedge clk);
    rst_n = 1;
    cyc(nv(1, 1, 0, 0, 0, 0, 1), 0);
    for (int i = 0; i < 3000; i++) begin
      vec_t v;
      int   r;
      cmd_if = 16'($urandom); cmd_fn = 16'($urandom); cmd_ro = 8'($urandom);
      cmd_data = {$urandom, $urandom};
      r = $urandom_range(0, 7);
      v = mk($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             6'($urandom_range(0, 9)), $urandom, $urandom_range(0, 3) != 0, $urandom,
             $urandom_range(0, 2) != 0, $urandom_range(0, 7) != 0, 0, 0, 0, 0, 0);
      if (r < 5 && mq.size() > 0) v.rid = 6'(mq[$urandom_range(0, mq.size() - 1)].tag);
      else if (r == 5) v.rid = 6'(m_tail);
      cyc(v, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
